// File: rtl/audio_mix_i2s_out.sv
// audio_mix_i2s_out: NUM_SRC-source stereo mixer with gain, soft mute and saturation, plus I2S transmitter
module audio_mix_i2s_out #(
    parameter int CLK_RATE   = 24576000,
    parameter int AUDIO_RATE = 48000,
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_l,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_r,
    input  logic [NUM_SRC-1:0]            src_signed,
    input  logic [NUM_SRC*8-1:0]          gain,
    input  logic                          mute,
    output logic                          sample_ce,
    output logic [DATA_WIDTH-1:0]         audio_l,
    output logic [DATA_WIDTH-1:0]         audio_r,
    output logic                          i2s_bclk,
    output logic                          i2s_lrclk,
    output logic                          i2s_data
);
    localparam int CPS = CLK_RATE / AUDIO_RATE;
    localparam int B   = CPS / 64;
    localparam int SW  = $clog2(B);
    localparam int IW  = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;
    localparam int PW  = DATA_WIDTH + 9;
    localparam int AW  = PW + $clog2(NUM_SRC);
    localparam logic signed [AW-1:0] MAXV = AW'(2 ** (DATA_WIDTH - 1) - 1);
    localparam logic signed [AW-1:0] MINV = ~MAXV;

    typedef enum logic [2:0] {IDLE, ACC, SAT, RAMP, OUT} state_t;

    state_t                       state_q, state_d;
    logic [SW-1:0]                sub_q, sub_d;
    logic [5:0]                   k_q, k_d;
    logic [IW-1:0]                idx_q, idx_d;
    logic signed [AW-1:0]         acc_l_q, acc_l_d, acc_r_q, acc_r_d;
    logic signed [DATA_WIDTH-1:0] sat_l_q, sat_l_d, sat_r_q, sat_r_d;
    logic signed [DATA_WIDTH-1:0] audio_l_q, audio_l_d, audio_r_q, audio_r_d;
    logic [DATA_WIDTH-1:0]        tx_l_q, tx_l_d, tx_r_q, tx_r_d;
    logic [7:0]                   ramp_q, ramp_d;
    logic                         last_sub, last_clk;
    logic [DATA_WIDTH-1:0]        cur_l, cur_r, tx_word;
    logic [7:0]                   cur_g;
    logic                         cur_s;
    logic [31:0]                  slot;

    function automatic logic signed [PW-1:0] scale(input logic [DATA_WIDTH-1:0] s, input logic sgn,
                                                   input logic [7:0] g);
        logic signed [DATA_WIDTH-1:0] v;
        v = sgn ? s : {~s[DATA_WIDTH-1], s[DATA_WIDTH-2:0]};
        return PW'(v) * PW'($signed({1'b0, g}));
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] clamp(input logic signed [AW-1:0] a);
        logic signed [AW-1:0] s;
        s = a >>> 7;
        return s > MAXV ? DATA_WIDTH'(MAXV) : s < MINV ? DATA_WIDTH'(MINV) : DATA_WIDTH'(s);
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] fade(input logic signed [DATA_WIDTH-1:0] s,
                                                          input logic [7:0] r);
        logic signed [PW-1:0] p;
        p = PW'(s) * PW'($signed({1'b0, r}));
        return DATA_WIDTH'(p >>> 7);
    endfunction

    assign last_sub  = sub_q == SW'(B - 1);
    assign last_clk  = last_sub && k_q == 6'd63;
    assign sample_ce = !reset && k_q == 6'd0 && sub_q == '0;
    assign i2s_bclk  = sub_q >= SW'(B / 2);
    assign i2s_lrclk = k_q >= 6'd31 && k_q <= 6'd62;
    assign tx_word   = k_q[5] ? tx_r_q : tx_l_q;
    assign slot      = {tx_word, {(32 - DATA_WIDTH){1'b0}}};
    // MSB lands on bit 0 of each slot, one bit after lrclk switches
    assign i2s_data  = slot[~k_q[4:0]];
    assign audio_l   = audio_l_q;
    assign audio_r   = audio_r_q;

    assign cur_l = src_l[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
    assign cur_r = src_r[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
    assign cur_g = gain[int'(idx_q)*8 +: 8];
    assign cur_s = src_signed[idx_q];

    always_comb begin
        sub_d  = last_sub ? '0 : sub_q + 1'b1;
        k_d    = last_sub ? k_q + 6'd1 : k_q;
        tx_l_d = last_clk ? audio_l_q : tx_l_q;
        tx_r_d = last_clk ? audio_r_q : tx_r_q;
        ramp_d = !sample_ce ? ramp_q :
                 mute ? (ramp_q == 8'd0 ? ramp_q : ramp_q - 8'd1) :
                 (ramp_q == 8'd128 ? ramp_q : ramp_q + 8'd1);
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        acc_l_d   = acc_l_q;
        acc_r_d   = acc_r_q;
        sat_l_d   = sat_l_q;
        sat_r_d   = sat_r_q;
        audio_l_d = audio_l_q;
        audio_r_d = audio_r_q;
        case (state_q)
            IDLE: begin
                if (sample_ce) begin
                    state_d = ACC;
                    idx_d   = '0;
                    acc_l_d = '0;
                    acc_r_d = '0;
                end
            end
            ACC: begin
                acc_l_d = acc_l_q + AW'(scale(cur_l, cur_s, cur_g));
                acc_r_d = acc_r_q + AW'(scale(cur_r, cur_s, cur_g));
                idx_d   = idx_q + 1'b1;
                state_d = int'(idx_q) == NUM_SRC - 1 ? SAT : ACC;
            end
            SAT: begin
                sat_l_d = clamp(acc_l_q);
                sat_r_d = clamp(acc_r_q);
                state_d = RAMP;
            end
            RAMP: begin
                audio_l_d = fade(sat_l_q, ramp_q);
                audio_r_d = fade(sat_r_q, ramp_q);
                state_d   = OUT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            sub_q     <= '0;
            k_q       <= '0;
            idx_q     <= '0;
            acc_l_q   <= '0;
            acc_r_q   <= '0;
            sat_l_q   <= '0;
            sat_r_q   <= '0;
            audio_l_q <= '0;
            audio_r_q <= '0;
            tx_l_q    <= '0;
            tx_r_q    <= '0;
            ramp_q    <= '0;
        end else begin
            state_q   <= state_d;
            sub_q     <= sub_d;
            k_q       <= k_d;
            idx_q     <= idx_d;
            acc_l_q   <= acc_l_d;
            acc_r_q   <= acc_r_d;
            sat_l_q   <= sat_l_d;
            sat_r_q   <= sat_r_d;
            audio_l_q <= audio_l_d;
            audio_r_q <= audio_r_d;
            tx_l_q    <= tx_l_d;
            tx_r_q    <= tx_r_d;
            ramp_q    <= ramp_d;
        end
    end
endmodule

// File: tb/tb_audio_mix_i2s_out.sv
// tb_audio_mix_i2s_out: random and directed checks of the mixer against a sample-level reference model
module tb_audio_mix_i2s_out;
    localparam int NS  = 4;
    localparam int DW  = 16;
    localparam int CPS = 128;
    localparam int B   = CPS / 64;

    logic            clk = 0;
    logic            reset = 1;
    logic [NS*DW-1:0] src_l = '0, src_r = '0;
    logic [NS-1:0]   src_signed = '1;
    logic [NS*8-1:0] gain = '0;
    logic            mute = 0;
    logic            sample_ce, i2s_bclk, i2s_lrclk, i2s_data;
    logic [DW-1:0]   audio_l, audio_r;

    audio_mix_i2s_out #(
        .CLK_RATE(CPS * 48000), .AUDIO_RATE(48000), .NUM_SRC(NS), .DATA_WIDTH(DW)
    ) dut (
        .clk(clk), .reset(reset), .src_l(src_l), .src_r(src_r), .src_signed(src_signed),
        .gain(gain), .mute(mute), .sample_ce(sample_ce), .audio_l(audio_l), .audio_r(audio_r),
        .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk), .i2s_data(i2s_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    // reference model: one value per sample period, derived from the source values seen
    // during each source's accumulate clock
    int mcyc, m_ramp, e_l, e_r, t_l, t_r, ph, k, j, si;
    int cap_l[NS], cap_r[NS], cap_g[NS];
    logic [DW-1:0] w;
    logic [35:0] exp_v, got_v;

    function automatic int to_int(input logic [DW-1:0] x, input bit sg);
        return sg ? int'($signed(x)) : int'(x) - (1 << (DW - 1));
    endfunction

    function automatic int mix(input int v[NS], input int g[NS], input int r);
        longint a;
        a = 0;
        for (int i = 0; i < NS; i++) a += longint'(v[i]) * g[i];
        a = a >>> 7;
        if (a > 32767) a = 32767;
        if (a < -32768) a = -32768;
        return int'((a * r) >>> 7);
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            mcyc = 0; m_ramp = 0; e_l = 0; e_r = 0; t_l = 0; t_r = 0;
        end else begin
            ph = mcyc % CPS;
            if (ph == 0) begin
                t_l = e_l;
                t_r = e_r;
                m_ramp = mute ? (m_ramp > 0 ? m_ramp - 1 : 0) : (m_ramp < 128 ? m_ramp + 1 : 128);
            end
            if (ph >= 1 && ph <= NS) begin
                si = ph - 1;
                cap_l[si] = to_int(src_l[si*DW +: DW], src_signed[si]);
                cap_r[si] = to_int(src_r[si*DW +: DW], src_signed[si]);
                cap_g[si] = int'(gain[si*8 +: 8]);
            end
            if (ph == NS + 3) begin
                e_l = mix(cap_l, cap_g, m_ramp);
                e_r = mix(cap_r, cap_g, m_ramp);
            end
            k = ph / B;
            j = k % 32;
            w = DW'(k < 32 ? t_l : t_r);
            exp_v = {ph == 0, (ph % B) >= B / 2, k >= 31 && k <= 62, j < DW ? w[DW-1-j] : 1'b0,
                     DW'(e_l), DW'(e_r)};
            got_v = {sample_ce, i2s_bclk, i2s_lrclk, i2s_data, audio_l, audio_r};
            check($sformatf("cycle_ph%0d", ph), 64'(got_v), 64'(exp_v));
            mcyc++;
        end
    end

    task automatic wait_ph(input int p);
        do begin
            @(posedge clk);
            #1;
        end while ((mcyc % CPS) != p);
    endtask

    task automatic set_src(input int i, input logic [DW-1:0] l, input logic [DW-1:0] r,
                           input logic [7:0] g, input bit sg);
        src_l[i*DW +: DW] = l;
        src_r[i*DW +: DW] = r;
        gain[i*8 +: 8] = g;
        src_signed[i] = sg;
    endtask

    logic [63:0] fr, lr;
    int n;

    initial begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("reset_state", {sample_ce, i2s_bclk, i2s_lrclk, i2s_data, audio_l, audio_r}, 0);
        @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        check("first_ce", sample_ce, 1);

        n = 0;
        do begin @(negedge clk); n++; end while (!sample_ce && n < 2 * CPS);
        check("ce_period", n, CPS);
        wait_ph(10);
        wait_ph(10);
        @(negedge clk);
        check("zero_gain_l", audio_l, 0);
        check("zero_gain_r", audio_r, 0);

        wait_ph(20);
        set_src(0, 16'h1000, 16'h0800, 8'd128, 1);
        repeat (130) wait_ph(20);
        wait_ph(10);
        @(negedge clk);
        check("unity_l", audio_l, 16'h1000);
        check("unity_r", audio_r, 16'h0800);
        wait_ph(20);
        set_src(0, 16'h0C00, 16'h0800, 8'd128, 1);
        wait_ph(6);
        @(negedge clk);
        check("latency_old", audio_l, 16'h1000);
        wait_ph(7);
        @(negedge clk);
        check("latency_new", audio_l, 16'h0C00);

        wait_ph(20);
        set_src(0, 16'h7000, 16'h7000, 8'd128, 1);
        set_src(1, 16'h7000, 16'h9000, 8'd128, 1);
        wait_ph(10);
        @(negedge clk);
        check("sat_pos", audio_l, 16'h7FFF);
        wait_ph(20);
        set_src(0, 16'h9000, 16'h9000, 8'd128, 1);
        set_src(1, 16'h9000, 16'h9000, 8'd128, 1);
        wait_ph(10);
        @(negedge clk);
        check("sat_neg", audio_l, 16'h8000);

        wait_ph(20);
        set_src(0, 16'h0000, 16'h0000, 8'd0, 1);
        set_src(1, 16'h0000, 16'h0000, 8'd0, 1);
        set_src(2, 16'h8000, 16'h8000, 8'd128, 0);
        wait_ph(10);
        @(negedge clk);
        check("offset_mid", audio_l, 16'h0000);
        wait_ph(20);
        set_src(2, 16'hFFFF, 16'h0000, 8'd128, 0);
        wait_ph(10);
        @(negedge clk);
        check("offset_max", audio_l, 16'h7FFF);
        check("offset_min", audio_r, 16'h8000);

        wait_ph(20);
        set_src(2, 16'h0000, 16'h0000, 8'd0, 1);
        set_src(0, 16'h4000, 16'h4000, 8'd128, 1);
        wait_ph(10);
        @(negedge clk);
        check("tone", audio_l, 16'h4000);
        wait_ph(20);
        mute = 1;
        wait_ph(10);
        @(negedge clk);
        check("mute_step1", audio_l, 16'h3F80);
        repeat (63) wait_ph(10);
        @(negedge clk);
        check("mute_ramp64", audio_l, 16'h2000);
        wait_ph(20);
        mute = 0;
        wait_ph(10);
        @(negedge clk);
        check("unmute_step", audio_l, 16'h2080);

        wait_ph(20);
        set_src(0, 16'hA5A5, 16'h5A5A, 8'd128, 1);
        repeat (66) wait_ph(20);
        wait_ph(CPS - 1);
        fr = '0;
        lr = '0;
        for (int c = 0; c < CPS; c++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            if (c % B == B / 2) begin
                fr[63 - c / B] = i2s_data;
                lr[63 - c / B] = i2s_lrclk;
            end
        end
        check("i2s_left", fr[63:32], 32'hA5A50000);
        check("i2s_right", fr[31:0], 32'h5A5A0000);
        check("i2s_lrclk", lr, 64'h0000_0001_FFFF_FFFE);

        for (int c = 0; c < 30 * CPS; c++) begin
            @(posedge clk);
            #1;
            src_l = {$urandom(), $urandom()};
            src_r = {$urandom(), $urandom()};
            src_signed = NS'($urandom());
            gain = $urandom();
            if ($urandom_range(0, 63) == 0) mute = !mute;
        end

        wait_ph($urandom_range(20, 100));
        reset = 1;
        @(negedge clk);
        check("ce_in_reset", sample_ce, 0);
        @(negedge clk);
        check("reset_next_clk", {sample_ce, i2s_bclk, i2s_lrclk, i2s_data, audio_l, audio_r}, 0);
        @(posedge clk);
        #1;
        reset = 0;
        mute = 0;
        gain = '0;
        src_signed = '1;
        set_src(0, 16'h1000, 16'h1000, 8'd128, 1);
        wait_ph(10);
        @(negedge clk);
        check("fadein_first", audio_l, 16'h0020);
        repeat (3) wait_ph(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
